// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader assembling LE 32-bit words into imem (write port mem_*), then holding start_o; handshake via byte_valid_i/byte_ready_o, control via load_req_i/len_i, status busy_o/done_o/err_o
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_req_i,
  input  logic [ADDR_W:0] len_i,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_data_i,
  output logic            byte_ready_o,
  output logic            mem_we_o,
  output logic [31:0]     mem_addr_o,
  output logic [31:0]     mem_data_o,
  output logic            start_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  state_t st, nxt;
  logic [ADDR_W:0] len, word_cnt;
  logic [1:0] byte_cnt;
  logic [31:0] asm_w;
  logic legal, req, hs;
  assign legal = len_i != '0 && len_i <= MAX_LEN;
  assign req = load_req_i && (st == IDLE || st == RUN);
  assign hs = byte_valid_i && st == LOAD;
  assign byte_ready_o = st == LOAD;
  assign mem_we_o = st == WRITE;
  assign start_o = st == RUN;
  assign busy_o = st == LOAD || st == WRITE;
  always_comb begin
    nxt = st;
    nxt = st == LOAD  ? (hs && byte_cnt == 2'd3 ? WRITE : LOAD) :
          st == WRITE ? (word_cnt + ONE == len ? RUN : LOAD) :
          req && legal ? LOAD : st;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      st <= IDLE;
      len <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_w <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      st <= nxt;
      done_o <= st == WRITE && nxt == RUN;
      if (req) err_o <= !legal;
      if (req && legal) begin
        len <= len_i;
        word_cnt <= '0;
        byte_cnt <= '0;
      end
      if (hs) begin
        asm_w[{byte_cnt, 3'b000} +: 8] <= byte_data_i;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (hs && byte_cnt == 2'd3) begin
        mem_data_o <= {byte_data_i, asm_w[23:0]};
        mem_addr_o <= 32'({word_cnt[ADDR_W-1:0], 2'b00});
      end
      if (st == WRITE) word_cnt <= word_cnt + ONE;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int MAX_WORDS = 256;
  logic clk_i = 0, rst_i = 0, load_req_i = 0, byte_valid_i = 0;
  logic [ADDR_W:0] len_i = '0;
  logic [7:0] byte_data_i = '0;
  logic byte_ready_o, mem_we_o, start_o, busy_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_data_o;
  int n_tests = 0, n_fail = 0, n_done = 0;
  logic [31:0] wa[$], wd[$];
  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_req_i(load_req_i), .len_i(len_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .start_o(start_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (mem_we_o) begin
      wa.push_back(mem_addr_o);
      wd.push_back(mem_data_o);
    end
    if (done_o) n_done++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic request(input logic [ADDR_W:0] len);
    @(negedge clk_i);
    load_req_i = 1;
    len_i = len;
    @(negedge clk_i);
    load_req_i = 0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int stall);
    repeat (stall) begin
      @(negedge clk_i);
      byte_valid_i = 0;
    end
    @(negedge clk_i);
    byte_valid_i = 1;
    byte_data_i = b;
    for (int i = 0; i < 20 && !byte_ready_o; i++) @(negedge clk_i);
    if (!byte_ready_o) chk("ready_timeout", 32'(byte_ready_o), 1);
  endtask
  task automatic send_word(input logic [31:0] w, input int stall_max);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, stall_max));
  endtask
  task automatic idle();
    @(negedge clk_i);
    byte_valid_i = 0;
  endtask
  task automatic wait_run(input string tag);
    for (int i = 0; i < 20 && !start_o; i++) @(negedge clk_i);
    chk({tag, "_start"}, 32'(start_o), 1);
    chk({tag, "_done_pulse"}, 32'(done_o), 1);
    @(negedge clk_i);
    chk({tag, "_done_low"}, 32'(done_o), 0);
  endtask
  task automatic two_word(input string tag, input int stall_max);
    int base, dbase;
    base = wa.size();
    dbase = n_done;
    request(2);
    chk({tag, "_ready"}, 32'(byte_ready_o), 1);
    chk({tag, "_start_low"}, 32'(start_o), 0);
    send_word(32'h00500013, stall_max);
    send_word(32'h00100093, stall_max);
    idle();
    wait_run(tag);
    repeat (4) @(negedge clk_i);
    chk({tag, "_start_hold"}, 32'(start_o), 1);
    chk({tag, "_nwrites"}, wa.size() - base, 2);
    chk({tag, "_ndone"}, n_done - dbase, 1);
    if (wa.size() - base == 2) begin
      chk({tag, "_a0"}, wa[base], 32'h0);
      chk({tag, "_d0"}, wd[base], 32'h00500013);
      chk({tag, "_a1"}, wa[base+1], 32'h4);
      chk({tag, "_d1"}, wd[base+1], 32'h00100093);
    end
  endtask
  initial begin
    int base;
    repeat (3) begin
      @(negedge clk_i);
      load_req_i = 1'($urandom);
      len_i = 9'($urandom);
      byte_valid_i = 1'($urandom);
      byte_data_i = 8'($urandom);
      chk("rst_outs", {mem_addr_o | mem_data_o, 24'b0, byte_ready_o, mem_we_o, start_o, busy_o, done_o, err_o}, 0);
    end
    @(negedge clk_i);
    load_req_i = 0;
    byte_valid_i = 0;
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    chk("post_rst_ready", 32'(byte_ready_o), 0);
    chk("post_rst_busy", 32'(busy_o), 0);
    two_word("two", 0);
    two_word("stall", 3);
    @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    rst_i = 1;
    base = wa.size();
    request(0);
    chk("len0_err", 32'(err_o), 1);
    chk("len0_idle", {30'b0, busy_o, byte_ready_o}, 0);
    request(MAX_WORDS + 1);
    chk("lenmax1_err", 32'(err_o), 1);
    chk("lenmax1_busy", 32'(busy_o), 0);
    request(1);
    chk("len1_err_clr", 32'(err_o), 0);
    chk("len1_busy", 32'(busy_o), 1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    idle();
    #2 rst_i = 0;
    #1 chk("async_rst", {28'b0, start_o, busy_o, byte_ready_o, mem_we_o}, 0);
    chk("async_rst_err", 32'(err_o), 0);
    @(negedge clk_i);
    rst_i = 1;
    chk("rst_nowrite", wa.size() - base, 0);
    request(1);
    send_word(32'hDDCCBBAA, 0);
    idle();
    wait_run("fresh");
    chk("fresh_nwrites", wa.size() - base, 1);
    if (wa.size() - base == 1) begin
      chk("fresh_addr", wa[base], 32'h0);
      chk("fresh_data", wd[base], 32'hDDCCBBAA);
    end
    request(0);
    chk("run_bad_err", 32'(err_o), 1);
    chk("run_bad_start", 32'(start_o), 1);
    base = wa.size();
    request(MAX_WORDS);
    chk("full_err_clr", 32'(err_o), 0);
    chk("full_start_low", 32'(start_o), 0);
    for (int w = 0; w < MAX_WORDS; w++) send_word(32'(w), 0);
    idle();
    wait_run("full");
    chk("full_nwrites", wa.size() - base, MAX_WORDS);
    if (wa.size() - base == MAX_WORDS)
      for (int w = 0; w < MAX_WORDS; w++) begin
        chk($sformatf("full_a%0d", w), wa[base+w], 32'(w * 4));
        chk($sformatf("full_d%0d", w), wd[base+w], 32'(w));
      end
    base = wa.size();
    request(1);
    chk("reload_start_low", 32'(start_o), 0);
    send_word(32'h12345678, 1);
    idle();
    wait_run("reload");
    chk("reload_nwrites", wa.size() - base, 1);
    if (wa.size() - base == 1) begin
      chk("reload_addr", wa[base], 32'h0);
      chk("reload_data", wd[base], 32'h12345678);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of the single-cycle CPU. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions. Writes each instruction into consecutive instruction-memory word slots through a write port, then holds the CPU `start_i` high once the programmed word count has been written. Reload requests while the CPU runs drop `start` and restart the load.

## Interface

Parameters:

- `ADDR_W`, default 8: word-index width; instruction memory holds 2^ADDR_W words.
- `MAX_WORDS`, default 256: largest accepted load length; must be ≤ 2^ADDR_W.

Ports:

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `load_req_i`  in  1  single-cycle request to begin a load.
- `len_i`  in  ADDR_W+1  word count, sampled in the cycle `load_req_i` is accepted.
- `byte_valid_i`  in  1  byte stream valid.
- `byte_data_i`  in  8  byte stream data.
- `byte_ready_o`  out  1  loader can accept a byte this cycle.
- `mem_we_o`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr_o`  out  32  byte address of the write, equal to word index × 4.
- `mem_data_o`  out  32  instruction word being written.
- `start_o`  out  1  level that drives the CPU `start_i`.
- `busy_o`  out  1  high in LOAD or WRITE.
- `done_o`  out  1  one-cycle pulse on entry to RUN.
- `err_o`  out  1  sticky flag: last request carried an illegal length.

## Operation

- States are IDLE, LOAD, WRITE and RUN. Reset puts the block in IDLE and sets every output, the word counter, the byte counter and the assembly register to 0.
- **IDLE**
  - `load_req_i` with 1 ≤ `len_i` ≤ MAX_WORDS: latch the length, clear `err_o`, clear both counters, go to LOAD.
  - `len_i` = 0 or `len_i` > MAX_WORDS: set `err_o`, stay in IDLE, perform no writes.
- **LOAD**
  - `byte_ready_o` = 1.
  - Each handshake (`byte_valid_i` and `byte_ready_o` both high) stores `byte_data_i` into lane `byte_cnt`: lane 0 is bits [7:0], lane 3 is bits [31:24]. Then `byte_cnt` increments.
  - The handshake with `byte_cnt` = 3 moves the block to WRITE.
  - Cycles with `byte_valid_i` low change nothing.
- **WRITE** (lasts exactly one cycle)
  - `byte_ready_o` = 0, `mem_we_o` = 1.
  - `mem_addr_o` = {`word_cnt`, 2'b00}, zero-extended to 32 bits.
  - `mem_data_o` = the assembled word.
  - `word_cnt` increments. If `word_cnt`+1 equals the latched length, go to RUN; otherwise return to LOAD with `byte_cnt` = 0.
- **RUN**
  - `start_o` = 1, held until reset or reload.
  - An accepted `load_req_i` follows the IDLE rules. A legal length goes to LOAD and `start_o` falls. An illegal length sets `err_o`, stays in RUN and leaves `start_o` high.
- `load_req_i` is ignored in LOAD and WRITE.
- Bytes presented outside LOAD are not consumed, because `byte_ready_o` = 0.
- Addresses never wrap: the length check guarantees `word_cnt` < MAX_WORDS.
- `mem_addr_o` and `mem_data_o` hold their last values when `mem_we_o` = 0. Only `mem_we_o` qualifies them.

## Timing

- All outputs are registered. No combinational path runs from inputs to outputs. `byte_ready_o` is decoded from the state register only.
- Request at edge T (state IDLE, legal length): LOAD from T+1, so `byte_ready_o` = 1 in the cycle after T.
- A fourth-byte handshake at edge T puts the block in WRITE during T..T+1, with `mem_we_o` high for that single cycle.
- Minimum throughput is 5 cycles per word: 4 byte cycles plus 1 write cycle.
- The final WRITE cycle is followed by RUN. In the first RUN cycle `start_o` rises and `done_o` is high for exactly that cycle.
- Reload from RUN: `start_o` is 0 from the cycle after the request edge.
- Reset asserted mid-operation: all outputs go to 0 immediately, without waiting for a clock. The partial word is discarded. After release the block is in IDLE and the CPU stays stalled.

## Test plan

- **Reset values:** assert `rst_i` = 0 with random inputs for 3 cycles, then release. All outputs must be 0 and `byte_ready_o` must stay 0 until a request.
- **Two-word load:**
  - Stimulus: `len_i` = 2, then bytes 13 00 50 00 93 00 10 00 (hex), valid every cycle.
  - Required: writes (addr 0x0, data 0x00500013) then (addr 0x4, data 0x00100093), each with a one-cycle `mem_we_o`. Then `done_o` pulses, `start_o` goes to 1 and holds.
- **Stalled stream:** the same two-word load with `byte_valid_i` low for 0-3 random cycles between bytes. Writes, data and addresses must be identical to the two-word case, with no extra writes.
- **Illegal length:**
  - `len_i` = 0 must set `err_o` = 1 with no `mem_we_o` and the state remaining IDLE.
  - A following request with `len_i` = MAX_WORDS+1 must keep `err_o` = 1.
  - A following request with `len_i` = 1 must clear `err_o`.
- **Reset mid-load:** assert reset after 2 bytes of a `len_i` = 1 load. Required: no write and `start_o` = 0. After release, a fresh 4-byte load writes only the new word to addr 0x0.
- **Full-size load and reload:**
  - Load MAX_WORDS words with data equal to the word index. The last write must go to addr (MAX_WORDS−1)×4, then `start_o` = 1.
  - A `load_req_i` with `len_i` = 1 issued in RUN must drop `start_o` the next cycle and rewrite addr 0x0.
